// File: rtl/traffic_signal.sv
// Sensor-adaptive single-approach traffic light controller.
// RED -> GREEN (extended by traffic, capped) -> YELLOW -> RED.
module traffic_signal #(
  parameter int unsigned RED_T     = 10,
  parameter int unsigned GREEN_MIN = 8,
  parameter int unsigned GREEN_MAX = 20,
  parameter int unsigned YELLOW_T  = 3
) (
  input  logic       rst,
  input  logic       clk,
  input  logic       traffic,
  output logic [1:0] signal
);

  localparam int unsigned MAX_RG =
    (RED_T > GREEN_MAX) ? RED_T : GREEN_MAX;
  localparam int unsigned MAX_D =
    (MAX_RG > YELLOW_T) ? MAX_RG : YELLOW_T;
  localparam int unsigned CW = $clog2(MAX_D + 1);

  localparam logic [CW-1:0] RED_LAST  = CW'(RED_T - 1);
  localparam logic [CW-1:0] GMIN_LAST = CW'(GREEN_MIN - 1);
  localparam logic [CW-1:0] GMAX_LAST = CW'(GREEN_MAX - 1);
  localparam logic [CW-1:0] YEL_LAST  = CW'(YELLOW_T - 1);

  if (RED_T == 0 || GREEN_MIN == 0 || YELLOW_T == 0) begin : g_bad_dur
    $error("traffic_signal: durations must be >= 1");
  end
  if (GREEN_MAX < GREEN_MIN) begin : g_bad_green
    $error("traffic_signal: GREEN_MAX < GREEN_MIN");
  end

  // Encoding equals the lamp code; 2'b11 is the illegal state.
  typedef enum logic [1:0] {
    S_RED    = 2'b00,
    S_YELLOW = 2'b01,
    S_GREEN  = 2'b10
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    signal_q, signal_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_RED;
      cnt_q    <= '0;
      signal_q <= 2'b00;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      signal_q <= signal_d;
    end
  end

  always_comb begin
    state_d = S_RED;
    cnt_d   = '0;
    case (state_q)
      S_RED: begin
        if (cnt_q >= RED_LAST) begin
          state_d = S_GREEN;
        end else begin
          state_d = S_RED;
          cnt_d   = cnt_q + 1'b1;
        end
      end
      S_GREEN: begin
        // An unknown sensor keeps GREEN until the cap forces exit.
        if (cnt_q >= GMAX_LAST) begin
          state_d = S_YELLOW;
        end else if (cnt_q >= GMIN_LAST && traffic == 1'b0) begin
          state_d = S_YELLOW;
        end else begin
          state_d = S_GREEN;
          cnt_d   = cnt_q + 1'b1;
        end
      end
      S_YELLOW: begin
        if (cnt_q >= YEL_LAST) begin
          state_d = S_RED;
        end else begin
          state_d = S_YELLOW;
          cnt_d   = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_RED;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    signal_d = 2'b00;
    case (state_d)
      S_GREEN:  signal_d = 2'b10;
      S_YELLOW: signal_d = 2'b01;
      default:  signal_d = 2'b00;
    endcase
  end

  assign signal = signal_q;

endmodule

// File: tb/tb_traffic_signal.sv
// Randomized self-checking bench for traffic_signal.
// A lamp/age reference model tracks the light cycle by cycle.
module tb_traffic_signal;

  localparam int RT = 10;
  localparam int GMN = 8;
  localparam int GMX = 20;
  localparam int YT = 3;

  logic       rst;
  logic       clk;
  logic       traffic;
  logic [1:0] signal;

  int checks = 0;
  int errors = 0;

  // model: lamp 0=RED 1=GREEN 2=YELLOW, age = cycles spent in lamp
  int m_lamp = 0;
  int m_age  = 0;
  logic tpat [0:63];

  traffic_signal #(
    .RED_T(RT), .GREEN_MIN(GMN),
    .GREEN_MAX(GMX), .YELLOW_T(YT)
  ) dut (
    .rst(rst),
    .clk(clk),
    .traffic(traffic),
    .signal(signal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [1:0] m_sig();
    case (m_lamp)
      1: return 2'b10;
      2: return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  task automatic model_step(input logic t);
    case (m_lamp)
      0: if (m_age == RT - 1) begin
        m_lamp = 1; m_age = 0;
      end else m_age++;
      1: if (m_age >= GMN - 1 && (t == 1'b0 || m_age == GMX - 1)) begin
        m_lamp = 2; m_age = 0;
      end else m_age++;
      default: if (m_age == YT - 1) begin
        m_lamp = 0; m_age = 0;
      end else m_age++;
    endcase
  endtask

  task automatic tick(input logic t);
    traffic = t;
    @(posedge clk);
    if (rst) model_step(t);
    #1;
  endtask

  task automatic sync_green();
    logic [1:0] prev;
    int n;
    n = 0;
    prev = signal;
    while (!(prev != 2'b10 && signal == 2'b10) && n < 80) begin
      prev = signal;
      tick(1'b0);
      n++;
    end
    if (n >= 80) begin
      checks++; errors++;
      $display("FAIL sync_green: no GREEN start within 80 cycles, signal=%b", signal);
    end
  endtask

  // Starts at GREEN cycle 0; returns run lengths and model mismatches.
  task automatic measure(output int g, output int y, output int r,
                         output int mm);
    int idx;
    g = 1; y = 0; r = 0; mm = 0; idx = 0;
    while (signal == 2'b10 && g <= 40) begin
      tick(tpat[idx]);
      idx++;
      if (signal !== m_sig()) mm++;
      if (signal == 2'b10) g++;
    end
    while (signal == 2'b01 && y <= 40) begin
      y++;
      tick(1'($urandom_range(0, 1)));
      if (signal !== m_sig()) mm++;
    end
    while (signal == 2'b00 && r <= 40) begin
      r++;
      tick(1'($urandom_range(0, 1)));
      if (signal !== m_sig()) mm++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    traffic = 1'b0;
    #2 rst = 1'b0;
    m_lamp = 0; m_age = 0;
    #1;
    checks++;
    if (signal !== 2'b00) begin
      errors++;
      $display("FAIL reset_async: signal=%b want 00", signal);
    end
    for (int i = 0; i < 3; i++) begin
      tick(1'($urandom_range(0, 1)));
      checks++;
      if (signal !== 2'b00) begin
        errors++;
        $display("FAIL reset_hold[%0d]: signal=%b want 00", i, signal);
      end
    end
    #3 rst = 1'b1;
    #1;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (signal !== 2'b00) begin
        errors++;
        $display("FAIL release_red[%0d]: signal=%b want 00", i, signal);
      end
      tick(1'($urandom_range(0, 1)));
    end
    checks++;
    if (signal !== 2'b10 || m_sig() !== 2'b10) begin
      errors++;
      $display("FAIL release_green: signal=%b want 10", signal);
    end
    for (int i = 0; i < 4; i++) tick(1'b1);
    checks++;
    if (signal !== 2'b10) begin
      errors++;
      $display("FAIL mid_green: signal=%b want 10", signal);
    end
    #3 rst = 1'b0;
    m_lamp = 0; m_age = 0;
    #1;
    checks++;
    if (signal !== 2'b00) begin
      errors++;
      $display("FAIL reset_mid_green: signal=%b want 00", signal);
    end
    tick(1'b1);
    #3 rst = 1'b1;
  endtask

  task automatic test_min_green();
    int g, y, r, mm;
    sync_green();
    for (int i = 0; i < 64; i++) tpat[i] = 1'b0;
    for (int rep = 0; rep < 2; rep++) begin
      measure(g, y, r, mm);
      checks++;
      if (g !== GMN || y !== YT || r !== RT || mm !== 0) begin
        errors++;
        $display("FAIL min_green[%0d]: g=%0d y=%0d r=%0d mm=%0d want 8 3 10 0",
                 rep, g, y, r, mm);
      end
      checks++;
      if (g + y + r !== 21) begin
        errors++;
        $display("FAIL min_period[%0d]: period=%0d want 21", rep, g + y + r);
      end
    end
  endtask

  task automatic test_max_green();
    int g, y, r, mm;
    sync_green();
    for (int i = 0; i < 64; i++) tpat[i] = 1'b1;
    measure(g, y, r, mm);
    checks++;
    if (g !== GMX || y !== YT || r !== RT || mm !== 0) begin
      errors++;
      $display("FAIL max_green: g=%0d y=%0d r=%0d mm=%0d want 20 3 10 0",
               g, y, r, mm);
    end
  endtask

  task automatic test_extension();
    int g, y, r, mm;
    sync_green();
    for (int i = 0; i < 64; i++) tpat[i] = (i < 12) ? 1'b1 : 1'b0;
    measure(g, y, r, mm);
    checks++;
    if (g !== 13 || y !== YT || mm !== 0) begin
      errors++;
      $display("FAIL extension: g=%0d y=%0d mm=%0d want 13 3 0", g, y, mm);
    end
  endtask

  task automatic test_pre_min_ignore();
    int g, y, r, mm;
    sync_green();
    for (int i = 0; i < 64; i++) tpat[i] = (i < 7) ? 1'b0 : 1'b1;
    measure(g, y, r, mm);
    checks++;
    if (g !== GMX || mm !== 0) begin
      errors++;
      $display("FAIL pre_min_ignore: g=%0d mm=%0d want 20 0", g, mm);
    end
  endtask

  task automatic test_random_green();
    int g, y, r, mm, want;
    for (int k = 0; k < 6; k++) begin
      sync_green();
      for (int i = 0; i < 64; i++) tpat[i] = 1'($urandom_range(0, 1));
      // first cycle at/after the minimum with no traffic, else the cap
      want = GMX;
      for (int c = GMX - 1; c >= GMN - 1; c--)
        if (tpat[c] == 1'b0) want = c + 1;
      measure(g, y, r, mm);
      checks++;
      if (g !== want || y !== YT || r !== RT || mm !== 0) begin
        errors++;
        $display("FAIL random_green[%0d]: g=%0d y=%0d r=%0d mm=%0d want %0d 3 10 0",
                 k, g, y, r, mm, want);
      end
    end
  endtask

  task automatic test_soak();
    logic [1:0] prev;
    int run;
    bit started;
    prev = signal;
    run = 0;
    started = 0;
    for (int i = 0; i < 200; i++) begin
      tick(1'($urandom_range(0, 1)));
      checks++;
      if (signal === 2'b11 || signal !== m_sig()) begin
        errors++;
        $display("FAIL soak_model[%0d]: signal=%b want %b", i, signal, m_sig());
      end
      if (signal !== prev) begin
        checks++;
        if (!((prev == 2'b00 && signal == 2'b10) ||
              (prev == 2'b10 && signal == 2'b01) ||
              (prev == 2'b01 && signal == 2'b00))) begin
          errors++;
          $display("FAIL soak_trans[%0d]: %b->%b", i, prev, signal);
        end
        if (started) begin
          checks++;
          if ((prev == 2'b10 && (run < GMN || run > GMX)) ||
              (prev == 2'b01 && run != YT) ||
              (prev == 2'b00 && run != RT)) begin
            errors++;
            $display("FAIL soak_len[%0d]: lamp=%b len=%0d", i, prev, run);
          end
        end
        started = 1;
        run = 1;
      end else begin
        run++;
      end
      prev = signal;
    end
  endtask

  initial begin
    traffic = 1'b0;
    rst = 1'b1;
    test_reset();
    test_min_green();
    test_max_green();
    test_extension();
    test_pre_min_ignore();
    test_random_green();
    test_soak();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/traffic_signal.md
Name: traffic_signal

Overview:
- Sensor-adaptive single-approach traffic light controller.
- Cycles the lamp RED -> GREEN -> YELLOW -> RED.
- GREEN is held at least GREEN_MIN cycles, then extended while the `traffic` sensor reports vehicles, capped at GREEN_MAX cycles.
- Sits between the vehicle-presence sensor and the lamp driver; output is a 2-bit registered lamp code.

Parameters:
- RED_T, default 10: RED duration in clock cycles (>=1).
- GREEN_MIN, default 8: minimum GREEN duration in cycles (>=1).
- GREEN_MAX, default 20: maximum GREEN duration in cycles (>=GREEN_MIN).
- YELLOW_T, default 3: YELLOW duration in cycles (>=1).

Ports:
- Declaration order is rst, clk, traffic, signal; positional instantiation relies on this order.
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- traffic  input  1  vehicle-presence sensor; 1 = vehicles waiting/flowing; sampled on rising clk.
- signal  output  2  lamp code: 2'b00 RED, 2'b01 YELLOW, 2'b10 GREEN; 2'b11 never driven.

Behaviour:
- One clock and one reset. Reset is asynchronous and active-low (rst=0 resets).
  - While rst=0: state=RED, signal=2'b00, cycle counter=0, immediately and without waiting for clk.
  - Release is sampled synchronously: the first rising edge with rst=1 counts as cycle 0 of RED.
- Moore FSM; signal is a registered decode of the state, with no combinational path from traffic to signal.
- Cycle counter `cnt`:
  - Width $clog2(max(RED_T,GREEN_MAX,YELLOW_T)+1).
  - Cleared to 0 on every state transition; otherwise increments by 1 per cycle.
  - Never wraps, because every state exits at or before its cap.
- RED: on the edge where cnt==RED_T-1, go to GREEN. RED lasts exactly RED_T cycles. traffic is ignored.
- GREEN: on each edge, with cnt>=GREEN_MIN-1, go to YELLOW if either:
  - traffic==0 at that edge, or
  - cnt==GREEN_MAX-1, regardless of traffic.
  - Otherwise stay in GREEN.
  - Resulting GREEN length is in [GREEN_MIN, GREEN_MAX] cycles.
  - traffic values before the minimum is reached have no effect.
- YELLOW: on the edge where cnt==YELLOW_T-1, go to RED. Exactly YELLOW_T cycles; traffic ignored.
- Simultaneous events:
  - Max cap and traffic==0 on the same edge: a single transition to YELLOW.
  - Reset asserted mid-state (any state, any cnt): immediate RED with cnt=0. No partial YELLOW is required.
- Illegal/unused state encoding: next edge forces RED, cnt=0.
- traffic X/unknown is not a legal operating condition. The design must still never output 2'b11.
- Total RED->RED period ranges from RED_T+GREEN_MIN+YELLOW_T to RED_T+GREEN_MAX+YELLOW_T cycles. Defaults give 21..33 cycles.
- Parameter legality: use elaboration-time checks (e.g. an initial-block $error) for GREEN_MAX<GREEN_MIN or any duration of 0.

Test Plan:
- Reset: hold rst=0 for 3 cycles, then assert rst=0 asynchronously between edges mid-GREEN.
  - Required: signal=2'b00 immediately in both cases.
  - After release: exactly 10 cycles of 2'b00, then 2'b10.
- Minimum green: traffic=0 constantly.
  - Required: GREEN lasts exactly 8 cycles, YELLOW 3, RED 10; pattern repeats with period 21.
- Maximum green: traffic=1 constantly.
  - Required: GREEN lasts exactly 20 cycles, then YELLOW 3 cycles, then RED.
- Extension: traffic=1 for GREEN cycles 0..11, traffic=0 at the edge ending cycle 12.
  - Required: GREEN length = 13 cycles, then YELLOW.
- Pre-minimum ignore: traffic=0 during GREEN cycles 0..6, traffic=1 from cycle 7 onward.
  - Required: no exit at cycles 0..6; GREEN extends to 20 cycles.
- Random soak: traffic randomized every cycle for 200 cycles.
  - Required: signal never 2'b11.
  - Only legal transitions occur (00->10->01->00).
  - Every GREEN length is in [8,20]; every YELLOW length is 3 and every RED length is 10.
